add_dec_ascii: RTL

Parametrised add/subtract unit with a sequential binary-to-decimal converter and ASCII formatter. It produces a right-aligned, sign-prefixed character string ready for the character-LCD driver. It generalises the fixed 8-bit adder/bin2dec path: configurable width and digit count, subtraction, signed mode, leading-zero blanking and a valid/ready handshake on both sides. It sits between operand sources (switches/registers) and the LCD controller's data input.

---
 rtl/add_dec_ascii_if.sv | 27 ++
 rtl/add_dec_ascii.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/add_dec_ascii_if.sv
// Request/result bundle for add_dec_ascii.
// The slave modport is the arithmetic unit; the master modport is whatever
// supplies operands and consumes the formatted character string.
interface add_dec_ascii_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
);
  logic                        valid_i;
  logic                        ready_o;
  logic [WIDTH-1:0]            a_i;
  logic [WIDTH-1:0]            b_i;
  logic                        op_i;
  logic                        signed_i;
  logic                        valid_o;
  logic                        ready_i;
  logic [8*(DIGITS+1)-1:0]     ascii_o;

  modport slave (
    input  valid_i, a_i, b_i, op_i, signed_i, ready_i,
    output ready_o, valid_o, ascii_o
  );

  modport master (
    output valid_i, a_i, b_i, op_i, signed_i, ready_i,
    input  ready_o, valid_o, ascii_o
  );
endinterface

// File: rtl/add_dec_ascii.sv
// Add/subtract unit followed by a sequential double-dabble binary-to-BCD
// converter and an ASCII formatter. The result is a right-aligned string with
// a fixed sign column on the left, ready for the character-LCD driver.
module add_dec_ascii #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  add_dec_ascii_if.slave  bus
);

  localparam int EW = WIDTH + 2;
  localparam int MW = WIDTH + 1;
  localparam int BW = 4 * DIGITS;
  localparam int AW = 8 * (DIGITS + 1);
  localparam int CW = $clog2(MW + 1);

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint DEC_RANGE = pow10(DIGITS);
  localparam longint BIN_RANGE = longint'(1) << (WIDTH + 1);

  // The largest magnitude needs WIDTH+1 bits, so the digit field must hold it.
  generate
    if (DEC_RANGE <= BIN_RANGE) begin : g_digits_too_small
      $error("add_dec_ascii: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    CONV,
    FMT,
    DONE
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              op_q;
  logic              signed_q;
  logic              neg_q;
  logic [MW-1:0]     mag_q;
  logic [BW-1:0]     bcd_q;
  logic [CW-1:0]     cnt_q;
  logic [AW-1:0]     ascii_q;
  logic              ready_q;
  logic              valid_q;

  logic [EW-1:0]     a_ext;
  logic [EW-1:0]     b_ext;
  logic [EW-1:0]     sum_ext;
  logic [MW-1:0]     mag_calc;
  logic [BW-1:0]     bcd_adj;
  logic [AW-1:0]     ascii_fmt;
  logic              seen_nz;
  logic [3:0]        digit;

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.ascii_o = ascii_q;

  // Exact WIDTH+2 bit sum/difference and its magnitude; |R| never exceeds
  // 2^(WIDTH+1)-2, so negating only the low WIDTH+1 bits is sufficient.
  always_comb begin
    a_ext    = signed_q ? {{2{a_q[WIDTH-1]}}, a_q} : {2'b00, a_q};
    b_ext    = signed_q ? {{2{b_q[WIDTH-1]}}, b_q} : {2'b00, b_q};
    sum_ext  = op_q ? (a_ext - b_ext) : (a_ext + b_ext);
    mag_calc = sum_ext[EW-1] ? ((~sum_ext[MW-1:0]) + MW'(1)) : sum_ext[MW-1:0];
  end

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Digits to characters, blanking zeros left of the first nonzero digit; the LSD always prints.
  always_comb begin
    ascii_fmt = '0;
    seen_nz   = 1'b0;
    digit     = 4'h0;
    ascii_fmt[AW-1 -: 8] = neg_q ? 8'h2D : 8'h20;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit = bcd_q[4*i +: 4];
      if ((digit != 4'h0) || (i == 0)) seen_nz = 1'b1;
      if (BLANK_LZ && !seen_nz) ascii_fmt[8*i +: 8] = 8'h20;
      else                      ascii_fmt[8*i +: 8] = 8'h30 + {4'h0, digit};
    end
  end

  // Control FSM with registered handshake outputs and the shared datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      ascii_q  <= {(DIGITS+1){8'h20}};
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      mag_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_i) begin
            a_q      <= bus.a_i;
            b_q      <= bus.b_i;
            op_q     <= bus.op_i;
            signed_q <= bus.signed_i;
            ready_q  <= 1'b0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          neg_q   <= sum_ext[EW-1];
          mag_q   <= mag_calc;
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= CONV;
        end
        CONV: begin
          {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
          cnt_q          <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH)) state_q <= FMT;
        end
        FMT: begin
          ascii_q <= ascii_fmt;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (bus.ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
